// File: rtl/router_pkg.sv
// router_pkg: shared widths and header layout for the router register stage.
// Default DATA_W/ADDR_W/NUM_PORTS, LEN_W derivation, header field struct.
package router_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int ADDR_W_DEF    = 2;
  localparam int NUM_PORTS_DEF = 3;
  localparam int LEN_W_DEF     = DATA_W_DEF - ADDR_W_DEF;

  // Header word: length in the upper bits, destination in the lower bits.
  typedef struct packed {
    logic [LEN_W_DEF-1:0]  len;
    logic [ADDR_W_DEF-1:0] addr;
  } hdr_t;

  function automatic int len_w(input int dw, input int aw);
    return dw - aw;
  endfunction

endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk: running XOR parity, parity capture and error flags.
// Build option: ROUTER_REG_LEN_CHK_EN adds the payload counter and len_err.
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_detect_add .. i_full     FSM strobes
//   i_pkt_valid, i_fifo_full   input word valid, selected FIFO full
//   i_low_pkt_valid            pkt_valid dropped during load (from top)
//   i_data, i_hdr, i_hold      input word, latched header, held word
//   i_hdr_len                  latched payload length
//   o_parity_done, o_err, o_len_err
module router_parity_chk
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_detect_add,
  input  logic              i_lfd_state,
  input  logic              i_ld_state,
  input  logic              i_laf_state,
  input  logic              i_full_state,
  input  logic              i_pkt_valid,
  input  logic              i_fifo_full,
  input  logic              i_low_pkt_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_hdr,
  input  logic [DATA_W-1:0] i_hold,
  input  logic [LEN_W-1:0]  i_hdr_len,
  output logic              o_parity_done,
  output logic              o_err,
  output logic              o_len_err
);

  logic [DATA_W-1:0] r_int_par;
  logic [DATA_W-1:0] r_ext_par;
  logic              r_done;
  logic              r_done_d;
  logic              r_err;

  logic w_acc;
  logic w_cap_ld;
  logic w_cap_laf;
  logic w_done_rise;

  // A payload word counts even when it is diverted into the hold register.
  assign w_acc       = i_ld_state && i_pkt_valid && !i_full_state;
  assign w_cap_ld    = i_ld_state && !i_pkt_valid && !i_fifo_full;
  // Parity word stalled in hold is recovered on the late-after-full pass.
  assign w_cap_laf   = i_laf_state && i_low_pkt_valid && !r_done;
  assign w_done_rise = r_done && !r_done_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_int_par <= '0;
      r_ext_par <= '0;
      r_done    <= 1'b0;
      r_done_d  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done_d <= r_done;
      if (i_detect_add) begin
        r_int_par <= '0;
        r_ext_par <= '0;
        r_done    <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        if (i_lfd_state)
          r_int_par <= r_int_par ^ i_hdr;
        else if (w_acc)
          r_int_par <= r_int_par ^ i_data;
        if (w_cap_ld) begin
          r_ext_par <= i_data;
          r_done    <= 1'b1;
        end else if (w_cap_laf) begin
          r_ext_par <= i_hold;
          r_done    <= 1'b1;
        end
        if (w_done_rise)
          r_err <= (r_int_par != r_ext_par);
      end
    end
  end

`ifdef ROUTER_REG_LEN_CHK_EN
  logic [LEN_W-1:0] r_pay_cnt;
  logic             r_len_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pay_cnt <= '0;
      r_len_err <= 1'b0;
    end else if (i_detect_add) begin
      r_pay_cnt <= '0;
      r_len_err <= 1'b0;
    end else begin
      if (w_acc && (r_pay_cnt != '1))
        r_pay_cnt <= r_pay_cnt + LEN_W'(1);
      if (w_done_rise)
        r_len_err <= (r_pay_cnt != i_hdr_len);
    end
  end

  assign o_len_err = r_len_err;
`else
  logic w_unused_len;
  assign w_unused_len = ^i_hdr_len;
  assign o_len_err    = 1'b0;
`endif

  assign o_parity_done = r_done;
  assign o_err         = r_err;

endmodule

// File: rtl/router_reg_gen.sv
// router_reg_gen: router datapath register stage between input port and FIFOs.
// Build option: ROUTER_REG_LEN_CHK_EN enables the payload length check.
// Ports:
//   clock, resetn          clock, async active-low reset
//   pkt_valid, data_in     input word and its valid
//   fifo_full              selected FIFO full
//   detect_add .. rst_int_reg  FSM state strobes
//   dout, dout_valid       word to FIFO and its write strobe
//   hdr_addr, hdr_len      latched header fields
//   parity_done, low_pkt_valid, err, len_err  status
module router_reg_gen
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_PORTS = NUM_PORTS_DEF
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       pkt_valid,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       fifo_full,
  input  logic                       detect_add,
  input  logic                       lfd_state,
  input  logic                       ld_state,
  input  logic                       laf_state,
  input  logic                       full_state,
  input  logic                       rst_int_reg,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic [ADDR_W-1:0]          hdr_addr,
  output logic [DATA_W-ADDR_W-1:0]   hdr_len,
  output logic                       parity_done,
  output logic                       low_pkt_valid,
  output logic                       err,
  output logic                       len_err
);

  localparam int LEN_W = len_w(DATA_W, ADDR_W);

  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_low_pkt_valid;

  logic w_addr_ok;

  assign w_addr_ok =
    ({1'b0, data_in[ADDR_W-1:0]} < (ADDR_W+1)'(NUM_PORTS));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hdr           <= '0;
      r_hold          <= '0;
      r_dout          <= '0;
      r_dout_valid    <= 1'b0;
      r_low_pkt_valid <= 1'b0;
    end else begin
      if (detect_add && pkt_valid && w_addr_ok)
        r_hdr <= data_in;

      // Priority order also resolves non one-hot strobes.
      r_dout_valid <= 1'b0;
      if (lfd_state) begin
        r_dout       <= r_hdr;
        r_dout_valid <= 1'b1;
      end else if (ld_state && !fifo_full) begin
        r_dout       <= data_in;
        r_dout_valid <= 1'b1;
      end else if (ld_state) begin
        r_hold <= data_in;
      end else if (laf_state) begin
        r_dout       <= r_hold;
        r_dout_valid <= 1'b1;
      end

      if (rst_int_reg)
        r_low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
        r_low_pkt_valid <= 1'b1;
    end
  end

  router_parity_chk #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) u_par (
    .i_clk           (clock),
    .i_rst_n         (resetn),
    .i_detect_add    (detect_add),
    .i_lfd_state     (lfd_state),
    .i_ld_state      (ld_state),
    .i_laf_state     (laf_state),
    .i_full_state    (full_state),
    .i_pkt_valid     (pkt_valid),
    .i_fifo_full     (fifo_full),
    .i_low_pkt_valid (r_low_pkt_valid),
    .i_data          (data_in),
    .i_hdr           (r_hdr),
    .i_hold          (r_hold),
    .i_hdr_len       (r_hdr[DATA_W-1:ADDR_W]),
    .o_parity_done   (parity_done),
    .o_err           (err),
    .o_len_err       (len_err)
  );

  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign hdr_addr      = r_hdr[ADDR_W-1:0];
  assign hdr_len       = r_hdr[DATA_W-1:ADDR_W];
  assign low_pkt_valid = r_low_pkt_valid;

endmodule

// File: tb/tb_router_reg_gen.sv
// tb_router_reg_gen: scoreboard bench for router_reg_gen (default parameters).
// Stimulus pushes expected FIFO words and error flags; a monitor pops them.
module tb_router_reg_gen;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] hdr_addr;
  logic [5:0] hdr_len;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;
  logic       len_err;

`ifdef ROUTER_REG_LEN_CHK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  typedef struct {
    bit e;
    bit le;
  } eexp_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q_dout[$];
  eexp_t      q_err[$];

  always #5 clock = ~clock;

  router_reg_gen dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .hdr_addr      (hdr_addr),
    .hdr_len       (hdr_len),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .len_err       (len_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every written word and the err/len_err pair
  // one cycle after parity_done first rises.
  logic  pd_last = 1'b0;
  bit    pd_rise = 1'b0;
  eexp_t m_ex;
  logic [7:0] m_d;

  always @(negedge clock) begin
    if (!resetn) begin
      pd_last = 1'b0;
      pd_rise = 1'b0;
    end else begin
      if (pd_rise) begin
        if (q_err.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL err_unexpected: got err=%0b, none expected", err);
        end else begin
          m_ex = q_err.pop_front();
          chk("err", err, m_ex.e);
          chk("len_err", len_err, m_ex.le);
        end
      end
      pd_rise = parity_done && !pd_last;
      pd_last = parity_done;
      if (dout_valid) begin
        if (q_dout.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_unexpected: got %0h, none expected", dout);
        end else begin
          m_d = q_dout.pop_front();
          chk("dout", dout, m_d);
        end
      end
    end
  end

  task automatic step(input logic da, input logic lfd, input logic ld,
                      input logic laf, input logic fs, input logic rir,
                      input logic pv, input logic ff, input logic [7:0] d);
    detect_add  = da;
    lfd_state   = lfd;
    ld_state    = ld;
    laf_state   = laf;
    full_state  = fs;
    rst_int_reg = rir;
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic t_idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic t_det(input logic [7:0] h);
    step(1, 0, 0, 0, 0, 0, 1, 0, h);
  endtask

  task automatic t_lfd(input logic [7:0] exp_hdr);
    q_dout.push_back(exp_hdr);
    step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
  endtask

  task automatic t_ld(input logic [7:0] d, input logic pv, input logic ff);
    if (!ff) q_dout.push_back(d);
    step(0, 0, 1, 0, 0, 0, pv, ff, d);
  endtask

  task automatic t_full();
    step(0, 0, 0, 0, 1, 0, 1, 0, 8'h00);
  endtask

  task automatic t_laf(input logic [7:0] exp_hold);
    q_dout.push_back(exp_hold);
    step(0, 0, 0, 1, 0, 0, 1, 0, 8'h00);
  endtask

  task automatic t_rir();
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
  endtask

  // stall selects which load sees fifo_full: 0..2 payload, 3 parity word.
  task automatic pkt(input logic [7:0] h, input logic [7:0] p0,
                     input logic [7:0] p1, input logic [7:0] p2,
                     input logic [7:0] par, input int stall,
                     input bit e, input bit le);
    logic [7:0] p[3];
    eexp_t      x;
    p    = '{p0, p1, p2};
    x.e  = e;
    x.le = le;
    t_det(h);
    t_lfd(h);
    for (int i = 0; i < 3; i++) begin
      if (stall == i) begin
        t_ld(p[i], 1'b1, 1'b1);
        t_full();
        t_laf(p[i]);
      end else begin
        t_ld(p[i], 1'b1, 1'b0);
      end
    end
    q_err.push_back(x);
    if (stall == 3) begin
      t_ld(par, 1'b0, 1'b1);
      chk("lpv_set_stall", low_pkt_valid, 1'b1);
      t_full();
      t_laf(par);
      t_rir();
    end else begin
      t_ld(par, 1'b0, 1'b0);
      t_idle();
      t_rir();
    end
    chk("lpv_clr", low_pkt_valid, 1'b0);
    t_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 8'h00);
    chk({tag, "_dout_valid"}, dout_valid, 1'b0);
    chk({tag, "_hdr_addr"}, hdr_addr, 2'd0);
    chk({tag, "_hdr_len"}, hdr_len, 6'd0);
    chk({tag, "_parity_done"}, parity_done, 1'b0);
    chk({tag, "_low_pkt_valid"}, low_pkt_valid, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_len_err"}, len_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    pkt_valid   = 1'b0;
    fifo_full   = 1'b0;
    data_in     = 8'h00;
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Clean packet: 0E ^ A5 ^ 3C ^ FF = 68.
    pkt(8'h0E, 8'hA5, 8'h3C, 8'hFF, 8'h68, -1, 1'b0, 1'b0);
    chk("hdr_addr", hdr_addr, 2'd2);
    chk("hdr_len", hdr_len, 6'd3);

    // Wrong parity word.
    pkt(8'h0E, 8'hA5, 8'h3C, 8'hFF, 8'h69, -1, 1'b1, 1'b0);

    // Rejected address 3; detect_add still clears err.
    t_det(8'h0F);
    chk("err_cleared", err, 1'b0);
    chk("pd_cleared", parity_done, 1'b0);
    chk("hdr_addr_kept", hdr_addr, 2'd2);
    chk("hdr_len_kept", hdr_len, 6'd3);
    // pkt_valid drops in load: parity 55 vs cleared int parity 0.
    q_err.push_back('{e: 1'b1, le: LEN_EN});
    t_ld(8'h55, 1'b0, 1'b0);
    chk("lpv_set", low_pkt_valid, 1'b1);
    t_idle();
    t_rir();
    chk("lpv_rir", low_pkt_valid, 1'b0);
    // Set and clear in the same cycle: clear wins.
    step(0, 0, 1, 0, 0, 1, 0, 1, 8'h77);
    chk("lpv_clr_wins", low_pkt_valid, 1'b0);
    t_idle();

    // FIFO full on payload 3C: held, replayed on laf.
    pkt(8'h0E, 8'hA5, 8'h3C, 8'hFF, 8'h68, 1, 1'b0, 1'b0);

    // FIFO full on parity word: captured from hold on laf.
    pkt(8'h0E, 8'hA5, 8'hFF, 8'h3C, 8'h68, 3, 1'b0, 1'b0);

    // Asynchronous reset mid-payload.
    t_det(8'h0E);
    t_lfd(8'h0E);
    t_ld(8'hA5, 1'b1, 1'b0);
    @(negedge clock);
    #2;
    resetn      = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    pkt_valid   = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #4;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    pkt(8'h0E, 8'hA5, 8'h3C, 8'hFF, 8'h68, -1, 1'b0, 1'b0);

    // Length 4 with 3 payload words: 12 ^ A5 ^ 3C ^ FF = 74.
    pkt(8'h12, 8'hA5, 8'h3C, 8'hFF, 8'h74, -1, 1'b0, LEN_EN);
    chk("hdr_len4", hdr_len, 6'd4);
    chk("hdr_addr2", hdr_addr, 2'd2);

    repeat (3) t_idle();
    chk("dout_queue_drained", q_dout.size(), 0);
    chk("err_queue_drained", q_err.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
Parametrised datapath register stage of the packet router. It sits between the input port and the per-destination FIFOs, under control of the router FSM's state strobes. It latches the header, forwards payload and parity to the FIFO write side, and holds one word while the FIFO is full. It accumulates XOR parity, compares it with the packet parity word, and flags errors. It generalises the 8-bit register stage: width, address field and port count are configurable, and it adds a dout_valid strobe and a payload counter.

Parameters:
DATA_W, 8, data/header word width
ADDR_W, 2, header address field width; header[ADDR_W-1:0]; LEN_W = DATA_W-ADDR_W is a localparam
NUM_PORTS, 3, number of valid destinations; a header address >= NUM_PORTS is rejected

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  input packet word valid
data_in  in  DATA_W  header/payload/parity word
fifo_full  in  1  selected FIFO full
detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  in  1 each  FSM strobes
dout  out  DATA_W  word to FIFO
dout_valid  out  1  dout carries a word to write this cycle
hdr_addr  out  ADDR_W  latched destination
hdr_len  out  LEN_W  latched payload length
parity_done  out  1  parity word captured
low_pkt_valid  out  1  pkt_valid dropped during load
err  out  1  parity mismatch
len_err  out  1  length mismatch (see Optional Feature)

Behaviour:
- resetn low, asynchronously: all outputs and internal registers go to 0, including hold_reg, int_parity, ext_parity and pay_cnt. Reset mid-packet discards the packet; the first post-reset packet behaves normally.
- Header latch: on detect_add && pkt_valid && data_in[ADDR_W-1:0] < NUM_PORTS, hdr_reg <= data_in. hdr_addr and hdr_len are its fields. A rejected address leaves hdr_reg unchanged.
- detect_add clears int_parity, ext_parity, pay_cnt, parity_done, err and len_err.
- dout path, registered, priority top-down; outputs update one cycle after the strobe:
  - lfd_state: dout <= hdr_reg, dout_valid <= 1.
  - ld_state && !fifo_full: dout <= data_in, dout_valid <= 1.
  - ld_state && fifo_full: hold_reg <= data_in, dout holds, dout_valid <= 0.
  - laf_state: dout <= hold_reg, dout_valid <= 1.
  - Otherwise: dout holds, dout_valid <= 0.
- int_parity:
  - On lfd_state: int_parity ^= hdr_reg.
  - On ld_state && pkt_valid && !full_state: int_parity ^= data_in. This includes a word diverted to hold_reg.
- pay_cnt: increments under the same condition as the data_in XOR. It saturates at 2^LEN_W-1.
- Parity capture:
  - ld_state && !pkt_valid && !fifo_full: ext_parity <= data_in.
  - laf_state && low_pkt_valid && !parity_done: ext_parity <= hold_reg.
  - parity_done <= 1 on either capture and stays set until detect_add or reset.
- err: registered one cycle after parity_done is first high, err <= (int_parity != ext_parity). It holds until detect_add.
- low_pkt_valid: set on ld_state && !pkt_valid. Cleared on rst_int_reg; clear wins if both occur in the same cycle.
- Simultaneous strobes: the FSM guarantees the states are one-hot. Where they are not, the dout priority list above applies.

Optional Feature:
- ROUTER_REG_LEN_CHK_EN defined: len_err is registered in the same cycle as err, len_err <= (pay_cnt != hdr_len), and cleared on detect_add.
- Undefined: len_err is tied to 0 and pay_cnt is not synthesised. The port list is identical in both builds.

Decomposition:
- Package router_pkg holds:
  - default DATA_W/ADDR_W/NUM_PORTS constants
  - LEN_W derivation
  - header field typedef (addr, len)
- One natural sub-module, router_parity_chk, contains int_parity, ext_parity, parity_done, err and the optional pay_cnt/len_err.

Test Plan:
- Defaults; header 8'h0E (len 3, addr 2); payload A5, 3C, FF; parity 8'h68 → dout sequence 0E, A5, 3C, FF, 68 with dout_valid high per word; parity_done=1, then err=0 the next cycle.
- Same packet with parity 8'h69 → err=1 one cycle after parity_done, cleared on the next detect_add.
- fifo_full=1 during ld of payload 3C → dout_valid=0 that cycle; hold_reg=3C; on laf_state, dout=3C with dout_valid=1; int_parity unaffected, err=0.
- Header 8'h0F (addr 3, NUM_PORTS=3) → hdr_reg unchanged; then pkt_valid drops with ld_state → low_pkt_valid=1; rst_int_reg → low_pkt_valid=0.
- resetn pulsed low mid-payload (asynchronously, between edges) → every output is 0 immediately; the next clean packet passes with err=0.
- With ROUTER_REG_LEN_CHK_EN: header 8'h12 (len 4) with 3 payload words and correct parity → err=0, len_err=1. Without the macro → len_err=0.
